// File: rtl/sap1_pkg.sv
// Shared types and constants for the SAP-1 controller/sequencer.
package sap1_pkg;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  // Control word in W-bus datasheet order.
  typedef struct packed {
    logic cp;
    logic ep;
    logic lm_bar;
    logic ce_bar;
    logic li_bar;
    logic ei_bar;
    logic la_bar;
    logic ea;
    logic su;
    logic eu;
    logic lb_bar;
    logic lo_bar;
  } ctrl_word_t;

  // Every control deasserted: active-high at 0, active-low at 1.
  localparam ctrl_word_t CTRL_IDLE = '{
    cp: 1'b0, ep: 1'b0, lm_bar: 1'b1, ce_bar: 1'b1, li_bar: 1'b1, ei_bar: 1'b1,
    la_bar: 1'b1, ea: 1'b0, su: 1'b0, eu: 1'b0, lb_bar: 1'b1, lo_bar: 1'b1
  };

  // Bit positions of each T-state in the one-hot ring.
  localparam int T1 = 0;
  localparam int T2 = 1;
  localparam int T3 = 2;
  localparam int T4 = 3;
  localparam int T5 = 4;
  localparam int T6 = 5;

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot T-state ring. Reset loads T1; a halt request parks the ring at
// all-zeros, and an all-zero ring stays there until reset.
module sap1_ring_counter #(
  parameter int NUM_TSTATES = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   halt_req,
  output logic [NUM_TSTATES-1:0] t_state
);

  // Rotate one position per clock; zero rotates to zero, which holds HALT.
  always_ff @(posedge clk) begin
    if (rst)           t_state <= NUM_TSTATES'(1);
    else if (halt_req) t_state <= '0;
    else               t_state <= {t_state[NUM_TSTATES-2:0], t_state[NUM_TSTATES-1]};
  end

endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller/sequencer: T-state ring plus opcode decode into the
// 12-signal control word, with HLT handling.
// Optional macro SAP1_ILLEGAL_OP_HALT_EN: undefined opcodes seen in T4 halt
// the machine and raise the sticky illegal_op flag; otherwise they act as NOPs.
module sap1_controller_sequencer
  import sap1_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 4,
  parameter int NUM_TSTATES       = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction_bus,
  output logic [NUM_TSTATES-1:0]       t_state,
  output logic                         Cp,
  output logic                         Ep,
  output logic                         Lm_bar,
  output logic                         CE_bar,
  output logic                         Li_bar,
  output logic                         Ei_bar,
  output logic                         La_bar,
  output logic                         Ea,
  output logic                         Su,
  output logic                         Eu,
  output logic                         Lb_bar,
  output logic                         Lo_bar,
  output logic                         hlt,
  output logic                         illegal_op
);

  localparam logic [INSTRUCTION_WIDTH-1:0] LDA = INSTRUCTION_WIDTH'(OP_LDA);
  localparam logic [INSTRUCTION_WIDTH-1:0] ADD = INSTRUCTION_WIDTH'(OP_ADD);
  localparam logic [INSTRUCTION_WIDTH-1:0] SUB = INSTRUCTION_WIDTH'(OP_SUB);
  localparam logic [INSTRUCTION_WIDTH-1:0] OUT = INSTRUCTION_WIDTH'(OP_OUT);
  localparam logic [INSTRUCTION_WIDTH-1:0] HLT = INSTRUCTION_WIDTH'(OP_HLT);

  logic       halt_q;
  logic       halt_req;
  logic       stop_op;
  ctrl_word_t cw;

`ifdef SAP1_ILLEGAL_OP_HALT_EN
  logic op_legal;
  logic illegal_q;

  assign op_legal = (instruction_bus == LDA) || (instruction_bus == ADD) ||
                    (instruction_bus == SUB) || (instruction_bus == OUT) ||
                    (instruction_bus == HLT);
  assign stop_op  = (instruction_bus == HLT) || !op_legal;

  // Sticky record that an undefined opcode caused the halt.
  always_ff @(posedge clk) begin
    if (rst)                                illegal_q <= 1'b0;
    else if (t_state[T4] && !op_legal)      illegal_q <= 1'b1;
  end

  assign illegal_op = illegal_q;
`else
  assign stop_op    = (instruction_bus == HLT);
  assign illegal_op = 1'b0;
`endif

  // Halting is decided at the edge that ends T4, in place of advancing to T5.
  assign halt_req = t_state[T4] && stop_op;

  sap1_ring_counter #(.NUM_TSTATES(NUM_TSTATES)) u_ring (
    .clk      (clk),
    .rst      (rst),
    .halt_req (halt_req),
    .t_state  (t_state)
  );

  // HALT flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst)           halt_q <= 1'b0;
    else if (halt_req) halt_q <= 1'b1;
  end

  assign hlt = halt_q && !rst;

  // Control word decode: fetch in T1..T3, opcode-driven execute in T4..T6.
  always_comb begin
    cw = CTRL_IDLE;
    if (!rst && !halt_q) begin
      if (t_state[T1]) begin
        cw.ep     = 1'b1;
        cw.lm_bar = 1'b0;
      end else if (t_state[T2]) begin
        cw.cp     = 1'b1;
      end else if (t_state[T3]) begin
        cw.ce_bar = 1'b0;
        cw.li_bar = 1'b0;
      end else if (t_state[T4]) begin
        if (instruction_bus == LDA || instruction_bus == ADD || instruction_bus == SUB) begin
          cw.ei_bar = 1'b0;
          cw.lm_bar = 1'b0;
        end else if (instruction_bus == OUT) begin
          cw.ea     = 1'b1;
          cw.lo_bar = 1'b0;
        end
      end else if (t_state[T5]) begin
        if (instruction_bus == LDA) begin
          cw.ce_bar = 1'b0;
          cw.la_bar = 1'b0;
        end else if (instruction_bus == ADD || instruction_bus == SUB) begin
          cw.ce_bar = 1'b0;
          cw.lb_bar = 1'b0;
        end
      end else if (t_state[T6]) begin
        if (instruction_bus == ADD || instruction_bus == SUB) begin
          cw.eu     = 1'b1;
          cw.la_bar = 1'b0;
          cw.su     = (instruction_bus == SUB);
        end
      end
    end
  end

  assign Cp     = cw.cp;
  assign Ep     = cw.ep;
  assign Lm_bar = cw.lm_bar;
  assign CE_bar = cw.ce_bar;
  assign Li_bar = cw.li_bar;
  assign Ei_bar = cw.ei_bar;
  assign La_bar = cw.la_bar;
  assign Ea     = cw.ea;
  assign Su     = cw.su;
  assign Eu     = cw.eu;
  assign Lb_bar = cw.lb_bar;
  assign Lo_bar = cw.lo_bar;

endmodule
